// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART (RX/TX FSM states, parity modes, divisor helpers).
package uart_pkg;

    localparam int DIV_W        = 16;
    localparam int MIN_DIV_DFLT = 3;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_e;

    // Mode 2'b11 is reserved and behaves as no parity.
    function automatic parity_e decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d,
                                                   input logic [DIV_W-1:0] lo);
        return (d < lo) ? lo : d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer: expires at zero and reloads to div, so each bit lasts div+1 clocks.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             expire_o,
    output logic             half_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        expire_o = (cnt_q == '0);
        half_o   = (cnt_q <= (div_i >> 1));
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (expire_o) begin
            cnt_d = div_i;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sync_uart_param.sv
// Parametrised full-duplex UART: runtime divisor, 5-9 data bits, parity, 1/2 stop bits, TX holding register.
// Optional SYNC_UART_TX_ALIGN_EN re-aligns the TX bit timer to the RX start edge.
module sync_uart_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned DEFAULT_DIV = 433,
    parameter int unsigned MIN_DIV     = MIN_DIV_DFLT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy
);

    localparam logic [DIV_W-1:0] MIN_DIV_L  = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DEF_DIV_L  = DIV_W'(DEFAULT_DIV);
    localparam logic [3:0]       LAST_BIT   = 4'(DATA_BITS - 1);

    // ---------------- RX ----------------
    logic                 rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_e            rx_state_q;
    logic [DIV_W-1:0]     rx_div_q;
    parity_e              rx_par_q;
    logic [3:0]           rx_cnt_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_pbit_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, rx_perr_q, rx_ferr_q, rx_ovr_q;

    logic [DIV_W-1:0] rx_div_new;
    logic             rx_edge, rx_expire, rx_tick, rx_deliver;
    logic             rx_perr_now, rx_ferr_now, rx_half_unused;

    assign rx_div_new  = clamp_div(baud_div, MIN_DIV_L);
    assign rx_edge     = rx_s3_q & ~rx_s2_q & (rx_state_q == RX_IDLE);
    assign rx_tick     = rx_expire & (rx_state_q != RX_IDLE);
    assign rx_deliver  = rx_tick & (rx_state_q == RX_STOP);
    assign rx_perr_now = (rx_par_q != PAR_NONE) & (^rx_shift_q ^ rx_pbit_q ^ (rx_par_q == PAR_ODD));
    assign rx_ferr_now = ~rx_s2_q;

    uart_bit_timer u_rx_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (rx_edge),
        .load_val_i (rx_div_new >> 1),
        .div_i      (rx_div_q),
        .expire_o   (rx_expire),
        .half_o     (rx_half_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_div_q   <= DEF_DIV_L;
            rx_par_q   <= PAR_NONE;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
            rx_pbit_q  <= 1'b0;
        end else begin
            rx_s1_q <= rxd;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            case (rx_state_q)
                RX_IDLE: if (rx_edge) begin
                    rx_div_q   <= rx_div_new;
                    rx_par_q   <= decode_parity(parity_mode);
                    rx_state_q <= RX_START;
                end
                RX_START: if (rx_tick) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_tick) begin
                    rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_cnt_q == LAST_BIT) begin
                        rx_state_q <= (rx_par_q != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 4'd1;
                    end
                end
                RX_PARITY: if (rx_tick) begin
                    rx_pbit_q  <= rx_s2_q;
                    rx_state_q <= RX_STOP;
                end
                RX_STOP: if (rx_tick) rx_state_q <= RX_IDLE;
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // A word arriving while the previous one is unconsumed is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            if (rx_deliver && (!rx_valid_q || rx_ready)) begin
                rx_data_q  <= rx_shift_q;
                rx_perr_q  <= rx_perr_now;
                rx_ferr_q  <= rx_ferr_now;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_deliver && rx_valid_q && !rx_ready) begin
                rx_ovr_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_ovr_q <= 1'b0;
            end
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_overrun    = rx_ovr_q;

    // ---------------- TX ----------------
    tx_state_e            tx_state_q;
    logic [DATA_BITS-1:0] tx_hold_q, tx_shift_q;
    logic                 tx_full_q;
    logic [DIV_W-1:0]     tx_div_q;
    logic                 tx_stop2_q, tx_par_en_q, tx_pbit_q, txd_q;
    logic [3:0]           tx_cnt_q;

    logic [DIV_W-1:0] tx_div_new, tx_load_val;
    parity_e          tx_par_new;
    logic             tx_expire, tx_half, tx_tick, tx_last_stop, tx_launch, tx_align, tx_load;

    assign tx_div_new   = clamp_div(baud_div, MIN_DIV_L);
    assign tx_par_new   = decode_parity(parity_mode);
    assign tx_last_stop = ((tx_state_q == TX_STOP1) && !tx_stop2_q) || (tx_state_q == TX_STOP2);

`ifdef SYNC_UART_TX_ALIGN_EN
    // Reload to div-3 absorbs the synchroniser/edge-detect latency so TX bit edges track RX.
    assign tx_align    = rx_edge & ((tx_state_q == TX_IDLE) | (tx_last_stop & tx_half));
    assign tx_tick     = tx_expire & (tx_state_q != TX_IDLE) & ~tx_align;
    assign tx_launch   = tx_full_q & ((tx_state_q == TX_IDLE) | (tx_tick & tx_last_stop) | tx_align);
    assign tx_load     = tx_launch | tx_align;
    assign tx_load_val = tx_align
                       ? (((tx_launch || tx_state_q == TX_IDLE) ? tx_div_new : tx_div_q) - DIV_W'(3))
                       : tx_div_new;
`else
    logic tx_half_unused;
    assign tx_half_unused = tx_half;
    assign tx_align    = 1'b0;
    assign tx_tick     = tx_expire & (tx_state_q != TX_IDLE);
    assign tx_launch   = tx_full_q & ((tx_state_q == TX_IDLE) | (tx_tick & tx_last_stop));
    assign tx_load     = tx_launch;
    assign tx_load_val = tx_div_new;
`endif

    uart_bit_timer u_tx_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tx_load),
        .load_val_i (tx_load_val),
        .div_i      (tx_div_q),
        .expire_o   (tx_expire),
        .half_o     (tx_half)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_hold_q   <= '0;
            tx_full_q   <= 1'b0;
            tx_shift_q  <= '0;
            tx_div_q    <= DEF_DIV_L;
            tx_stop2_q  <= 1'b0;
            tx_par_en_q <= 1'b0;
            tx_pbit_q   <= 1'b0;
            tx_cnt_q    <= '0;
            txd_q       <= 1'b1;
        end else begin
            if (tx_valid && !tx_full_q) begin
                tx_hold_q <= tx_data;
                tx_full_q <= 1'b1;
            end
            if (tx_launch) begin
                tx_full_q   <= 1'b0;
                tx_shift_q  <= tx_hold_q;
                tx_div_q    <= tx_div_new;
                tx_stop2_q  <= stop2;
                tx_par_en_q <= (tx_par_new != PAR_NONE);
                tx_pbit_q   <= ^tx_hold_q ^ (tx_par_new == PAR_ODD);
                tx_state_q  <= TX_START;
                txd_q       <= 1'b0;
            end else if (tx_tick) begin
                case (tx_state_q)
                    TX_START: begin
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                    TX_DATA: begin
                        if (tx_cnt_q == LAST_BIT) begin
                            txd_q      <= tx_par_en_q ? tx_pbit_q : 1'b1;
                            tx_state_q <= tx_par_en_q ? TX_PARITY : TX_STOP1;
                        end else begin
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_cnt_q   <= tx_cnt_q + 4'd1;
                        end
                    end
                    TX_PARITY: begin
                        txd_q      <= 1'b1;
                        tx_state_q <= TX_STOP1;
                    end
                    TX_STOP1: tx_state_q <= tx_stop2_q ? TX_STOP2 : TX_IDLE;
                    TX_STOP2: tx_state_q <= TX_IDLE;
                    default:  tx_state_q <= TX_IDLE;
                endcase
            end
        end
    end

    assign txd      = txd_q;
    assign tx_ready = ~tx_full_q;
    assign tx_busy  = (tx_state_q != TX_IDLE) | tx_full_q;

endmodule

// File: tb/tb_sync_uart_param.sv
// Self-checking bench for sync_uart_param: directed and randomized frames against a bit-level frame model.
module tb_sync_uart_param;

    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   baud_div = 16'd433;
    logic [1:0]    parity_mode = 2'b00;
    logic          stop2 = 1'b0;
    logic          rxd, rxd_drv = 1'b1, loop_en = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid, rx_ready = 1'b0;
    logic          rx_parity_err, rx_frame_err, rx_overrun;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, txd, tx_busy;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, fall_cyc = -1;
    bit txd_prev = 1'b1;

    typedef bit bitq_t[$];

    always #5 clk = ~clk;
    assign rxd = loop_en ? txd : rxd_drv;

    sync_uart_param #(.DATA_BITS(DB), .DEFAULT_DIV(433), .MIN_DIV(3)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode), .stop2(stop2),
        .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (txd_prev == 1'b1 && txd === 1'b0) fall_cyc = cyc;
        txd_prev = (txd === 1'b0) ? 1'b0 : 1'b1;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bit_len(input int d);
        return ((d < 3) ? 3 : d) + 1;
    endfunction

    // Line-level frame: start, data LSB first, optional parity, one or two stop bits.
    function automatic bitq_t frame(input int data, input int pm, input bit two_stop);
        bitq_t q;
        int ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < DB; i++) begin
            q.push_back(bit'((data >> i) & 1));
            ones += (data >> i) & 1;
        end
        if (pm == 1) q.push_back(bit'(ones % 2));
        if (pm == 2) q.push_back(bit'(1 - ones % 2));
        q.push_back(1'b1);
        if (two_stop) q.push_back(1'b1);
        return q;
    endfunction

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic tx_put(input int data);
        for (int i = 0; i < 6000 && tx_ready !== 1'b1; i++) @(negedge clk);
        chk("tx_ready_wait", tx_ready, 1);
        tx_data  = DB'(data);
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic tx_expect(input bitq_t bits, input int len, input int since, input string tag);
        int t0, a, b;
        for (int i = 0; i < 20 * len && fall_cyc < since; i++) @(negedge clk);
        chk({tag, " start_seen"}, 32'(fall_cyc >= since), 1);
        if (fall_cyc >= since) begin
            t0 = fall_cyc;
            for (int k = 0; k < bits.size(); k++) begin
                a = t0 + k * len;
                b = a + len - 1;
                if (k > 0) begin
                    wait_to(a);
                    chk($sformatf("%s bit%0d first", tag, k), txd, bits[k]);
                end
                wait_to(b);
                chk($sformatf("%s bit%0d last", tag, k), txd, bits[k]);
            end
        end
    endtask

    task automatic rx_drive(input bitq_t bits, input int len);
        foreach (bits[k]) begin
            rxd_drv = bits[k];
            repeat (len) @(negedge clk);
        end
        rxd_drv = 1'b1;
    endtask

    task automatic rx_take(input string tag, input int data, input bit perr, input bit ferr, input bit ovr);
        for (int i = 0; i < 6000 && rx_valid !== 1'b1; i++) @(negedge clk);
        chk({tag, " valid"}, rx_valid, 1);
        chk({tag, " data"}, rx_data, data & 32'hFF);
        chk({tag, " perr"}, rx_parity_err, perr);
        chk({tag, " ferr"}, rx_frame_err, ferr);
        chk({tag, " ovr"}, rx_overrun, ovr);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk({tag, " valid_clr"}, rx_valid, 0);
        chk({tag, " ovr_clr"}, rx_overrun, 0);
    endtask

    initial begin
        int since, d, pm, bd, w[3];
        bit s2;
        bitq_t q;

        repeat (3) @(negedge clk);
        chk("rst txd", txd, 1);
        chk("rst tx_ready", tx_ready, 1);
        chk("rst tx_busy", tx_busy, 0);
        chk("rst rx_valid", rx_valid, 0);
        chk("rst rx_data", rx_data, 0);
        chk("rst errs", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 at the reset-default rate, looped back.
        loop_en = 1'b1;
        since = cyc;
        tx_put(8'hA5);
        tx_expect(frame(8'hA5, 0, 0), 434, since, "a5");
        rx_take("a5 rx", 8'hA5, 0, 0, 0);

        // Random word, parity, stop and divisor (including sub-minimum divisors).
        for (int r = 0; r < 6; r++) begin
            d  = $urandom_range(0, 255);
            pm = $urandom_range(0, 3);
            s2 = 1'($urandom_range(0, 1));
            bd = $urandom_range(0, 12);
            baud_div = 16'(bd); parity_mode = 2'(pm); stop2 = s2;
            since = cyc;
            tx_put(d);
            tx_expect(frame(d, (pm == 3) ? 0 : pm, s2), bit_len(bd), since, $sformatf("rnd%0d", r));
            rx_take($sformatf("rnd%0d rx", r), d, 0, 0, 0);
        end

        // Back-to-back even parity, two stop bits, no idle gap.
        loop_en = 1'b0;
        baud_div = 16'd15; parity_mode = 2'b01; stop2 = 1'b1;
        since = cyc;
        tx_data = 8'h41; tx_valid = 1'b1;
        @(negedge clk);
        chk("b2b ready_low1", tx_ready, 0);
        tx_data = 8'h42;
        for (int i = 0; i < 100 && tx_ready !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("b2b ready_low2", tx_ready, 0);
        chk("b2b busy", tx_busy, 1);
        q = {frame(8'h41, 1, 1), frame(8'h42, 1, 1)};
        tx_expect(q, 16, since, "b2b");
        repeat (4) @(negedge clk);
        chk("b2b idle busy", tx_busy, 0);

        // Odd parity with a wrong parity bit, then a bad stop bit.
        baud_div = 16'd7; parity_mode = 2'b10; stop2 = 1'b0;
        q = frame(0, 2, 0);
        q[DB + 1] = 1'b0;
        rx_drive(q, 8);
        rx_take("par", 0, 1, 0, 0);
        parity_mode = 2'b00;
        q = frame(8'h55, 0, 0);
        q[DB + 1] = 1'b0;
        rx_drive(q, 8);
        repeat (16) @(negedge clk);
        rx_take("frm", 8'h55, 0, 1, 0);

        // Three words with no consumer: first retained, overrun flagged.
        foreach (w[i]) begin
            w[i] = $urandom_range(0, 255);
            rx_drive(frame(w[i], 0, 0), 8);
            repeat (16) @(negedge clk);
        end
        rx_take("ovr", w[0], 0, 0, 1);

        // Short glitch is a false start; then divisor below minimum.
        baud_div = 16'd15;
        rxd_drv = 1'b0;
        repeat (2) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch no_valid", rx_valid, 0);
        baud_div = 16'd1;
        d = $urandom_range(0, 255);
        rx_drive(frame(d, 0, 0), 4);
        rx_take("div1 rx", d, 0, 0, 0);

        // Reset in the middle of data bits forces txd high at once.
        baud_div = 16'd15;
        tx_put(8'h00);
        repeat (16 * 4) @(negedge clk);
        chk("pre_rst txd", txd, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst txd", txd, 1);
        chk("mid_rst tx_ready", tx_ready, 1);
        chk("mid_rst tx_busy", tx_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        loop_en = 1'b1;
        since = cyc;
        tx_put(8'h3C);
        tx_expect(frame(8'h3C, 0, 0), 16, since, "post_rst");
        rx_take("post_rst rx", 8'h3C, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
